nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/adder_ctrl_pkg.sv | 18 +
 rtl/nibble_adder.sv | 26 ++
 rtl/nibble_serial_adder.sv | 154 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adder_ctrl_pkg
// Shared definitions for the nibble-serial adder: the slice width and the
// control FSM state encoding.
// -----------------------------------------------------------------------------
package adder_ctrl_pkg;

   // Width of one adder slice; operands are processed this many bits per cycle.
   localparam int NIBBLE_W = 4;

   // IDLE: waiting for operands, RUN: one slice per cycle, DONE: result held.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : adder_ctrl_pkg

// File: rtl/nibble_adder.sv
// -----------------------------------------------------------------------------
// nibble_adder
// Purely combinational 4-bit adder slice with carry in and carry out. This is
// the only arithmetic in the serial adder; the top reuses it once per cycle.
//
// Ports:
//   a     [3:0]  slice of operand A
//   b     [3:0]  slice of operand B
//   c_in         carry into the slice
//   sum   [3:0]  slice sum
//   c_out        carry out of the slice
// -----------------------------------------------------------------------------
module nibble_adder
   import adder_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                c_in,
   output logic [NIBBLE_W-1:0] sum,
   output logic                c_out
);

   // Zero-extend every term so the carry lands in the extra bit.
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};

endmodule : nibble_adder

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two W-bit operands plus a carry-in using a single 4-bit adder slice,
// one nibble per clock, least-significant nibble first. Operands are captured
// on the accepting edge; the result is presented with out_valid NIBBLES cycles
// later and held until the consumer takes it with out_ready.
//
// Parameters:
//   NIBBLES  number of 4-bit slices per operand (1..16)
//   W        derived operand width, 4*NIBBLES
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   high in IDLE: operands can be accepted
//   a, b       W-bit operands
//   c_in       carry into the least-significant nibble
//   out_valid  high in DONE: result available
//   out_ready  consumer accepts the result
//   sum        W-bit result
//   c_out      carry out of the most-significant nibble
//   busy       high in RUN and DONE
// -----------------------------------------------------------------------------
module nibble_serial_adder
   import adder_ctrl_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLE_W * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         c_out,
   output logic         busy
);

   // Counter only has to reach NIBBLES-1; keep at least one bit for NIBBLES=1.
   localparam int              CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               carry_q, carry_d;

   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;

   // Current nibble of each captured operand, selected by the counter.
   assign slice_a = a_q[count_q*NIBBLE_W +: NIBBLE_W];
   assign slice_b = b_q[count_q*NIBBLE_W +: NIBBLE_W];

   nibble_adder u_nibble_adder (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_q),
      .sum   (slice_sum),
      .c_out (slice_cout)
   );

   // ---------------------------------------------------------------------------
   // Next-state and datapath update
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path through
      // the case statement leaves it unassigned, which would infer a latch.
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;

      unique case (state_q)
         IDLE: begin
            // in_ready is 1 throughout IDLE, so in_valid alone is the handshake.
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               count_d = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            sum_d[count_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
            carry_d = slice_cout;
            // Hold the counter on the last slice so it never wraps when
            // NIBBLES is a power of two.
            if (count_q == LAST_CNT) begin
               state_d = DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of the others, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // After the last slice the carry register holds the carry out of the MSB
   // nibble, so it doubles as c_out; nothing touches it in DONE.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign c_out     = carry_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder. A 4-nibble instance carries the
// bulk of the scenarios; a 1-nibble instance covers the single-slice case.
// Expected results come from plain integer addition of the operands.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

   localparam int N  = 4;
   localparam int W  = 4 * N;
   localparam int BOUND = 50;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
   logic [W-1:0] a, b, sum;

   logic         in_valid_1, in_ready_1, c_in_1, out_valid_1, out_ready_1, c_out_1, busy_1;
   logic [3:0]   a_1, b_1, sum_1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .busy(busy)
   );

   nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
      .a(a_1), .b(b_1), .c_in(c_in_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
      .sum(sum_1), .c_out(c_out_1), .busy(busy_1)
   );

   // Reference model: the full-width sum including the carry out.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation, then scramble the operand inputs so any late
   // sampling would corrupt the result. Returns once out_valid is seen (or the
   // bound expires) without releasing the result.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W-1:0] s, output logic co, output int lat);
      int n = 0;
      while (!in_ready && n < BOUND) begin tick(); n++; end
      in_valid = 1'b1; a = av; b = bv; c_in = cv;
      tick();
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < BOUND) begin tick(); lat++; end
      s = sum; co = c_out;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
      total_cnt++; if ({c_out, sum} !== 17'h0) $display("FAIL reset_result got=%h exp=0", {c_out, sum}); else pass_cnt++;
      #4 rst_n = 1'b1;
      tick();
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
      total_cnt++; if (in_ready_1 !== 1'b1) $display("FAIL reset_in_ready_n1 got=%b exp=1", in_ready_1); else pass_cnt++;
   endtask

   task automatic test_directed();
      logic [W-1:0] s; logic co; int lat;
      do_op(16'hFFFF, 16'h0001, 1'b0, s, co, lat);
      total_cnt++; if (lat !== N) $display("FAIL ffff_latency got=%0d exp=%0d", lat, N); else pass_cnt++;
      total_cnt++; if ({co, s} !== 17'h1_0000) $display("FAIL ffff_sum got=%h exp=10000", {co, s}); else pass_cnt++;
      release_result();
      do_op(16'h1234, 16'h4321, 1'b1, s, co, lat);
      total_cnt++; if ({co, s} !== 17'h0_5556) $display("FAIL 1234_sum got=%h exp=05556", {co, s}); else pass_cnt++;
      release_result();
   endtask

   task automatic test_stall();
      logic [W-1:0] s; logic co; int lat; int bad = 0;
      do_op(16'h1234, 16'h4321, 1'b1, s, co, lat);
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || sum !== 16'h5556 || c_out !== 1'b0 || in_ready !== 1'b0) bad++;
         tick();
      end
      total_cnt++; if (bad != 0) $display("FAIL stall_hold got=%0d_bad_cycles exp=0", bad); else pass_cnt++;
      release_result();
      total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release got=busy%b_rdy%b exp=busy0_rdy1", busy, in_ready); else pass_cnt++;
   endtask

   task automatic test_ignore_in_valid();
      int lat = 0; int bad = 0;
      in_valid = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b1;
      tick();
      a = 16'h0F0F; b = 16'h0101; c_in = 1'b0;
      while (!out_valid && lat < BOUND) begin
         if (in_ready !== 1'b0) bad++;
         tick(); lat++;
      end
      if (in_ready !== 1'b0) bad++;
      total_cnt++; if (bad != 0) $display("FAIL ignore_in_ready got=%0d_bad_cycles exp=0", bad); else pass_cnt++;
      total_cnt++; if (lat !== N || {c_out, sum} !== 17'h0_5556) $display("FAIL ignore_first got=lat%0d_%h exp=lat%0d_05556", lat, {c_out, sum}, N); else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL ignore_idle got=%b exp=1", in_ready); else pass_cnt++;
      tick();
      in_valid = 1'b0;
      total_cnt++; if (busy !== 1'b1) $display("FAIL ignore_second_accept got=%b exp=1", busy); else pass_cnt++;
      lat = 0;
      while (!out_valid && lat < BOUND) begin tick(); lat++; end
      total_cnt++; if ({c_out, sum} !== ref_add(16'h0F0F, 16'h0101, 1'b0)) $display("FAIL ignore_second got=%h exp=%h", {c_out, sum}, ref_add(16'h0F0F, 16'h0101, 1'b0)); else pass_cnt++;
      release_result();
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] s; logic co; int lat; int bad = 0;
      in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; c_in = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      total_cnt++; if ({out_valid, busy, c_out, sum} !== 19'h0) $display("FAIL abort_outputs got=%h exp=0", {out_valid, busy, c_out, sum}); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b exp=1", in_ready); else pass_cnt++;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      total_cnt++; if (bad != 0) $display("FAIL abort_no_pulse got=%0d_bad_cycles exp=0", bad); else pass_cnt++;
      do_op(16'h8000, 16'h8000, 1'b0, s, co, lat);
      total_cnt++; if ({co, s} !== 17'h1_0000 || lat !== N) $display("FAIL abort_after got=%h_lat%0d exp=10000_lat%0d", {co, s}, lat, N); else pass_cnt++;
      release_result();
   endtask

   task automatic test_random();
      logic [W-1:0] av, bv, s; logic cv, co; int lat; int stall;
      for (int i = 0; i < 25; i++) begin
         av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
         if (i == 0) begin av = '1; bv = '1; cv = 1'b1; end
         if (i == 1) begin av = '0; bv = '0; cv = 1'b0; end
         out_ready = 1'($urandom);   // no effect while nothing is valid
         do_op(av, bv, cv, s, co, lat);
         out_ready = 1'b0;
         total_cnt++; if (lat !== N) $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, N); else pass_cnt++;
         total_cnt++; if ({co, s} !== ref_add(av, bv, cv)) $display("FAIL rand_sum[%0d] got=%h exp=%h", i, {co, s}, ref_add(av, bv, cv)); else pass_cnt++;
         stall = $urandom_range(0, 3);
         for (int k = 0; k < stall; k++) tick();
         release_result();
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   // Operands presented continuously with the consumer always ready: results
   // must appear N cycles after the first accept and every N+2 cycles after.
   task automatic test_back_to_back();
      logic [W-1:0] av, bv; logic cv; int bad_v = 0; int bad_s = 0; int seen = 0; int n = 0;
      logic exp_v;
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
      in_valid = 1'b1; a = av; b = bv; c_in = cv; out_ready = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         exp_v = (cyc >= N + 1) && ((cyc - (N + 1)) % (N + 2) == 0);
         if (out_valid !== exp_v) bad_v++;
         if (out_valid === 1'b1) begin
            seen++;
            if ({c_out, sum} !== ref_add(av, bv, cv)) bad_s++;
         end
      end
      in_valid = 1'b0;
      while (busy && n < BOUND) begin tick(); n++; end
      out_ready = 1'b0;
      total_cnt++; if (bad_v != 0) $display("FAIL b2b_timing got=%0d_bad_cycles exp=0", bad_v); else pass_cnt++;
      total_cnt++; if (bad_s != 0 || seen != 5) $display("FAIL b2b_results got=%0d_bad_of_%0d exp=0_of_5", bad_s, seen); else pass_cnt++;
   endtask

   task automatic test_nibbles1();
      logic [3:0] av, bv; logic cv; int lat; logic [4:0] exp;
      for (int i = 0; i < 6; i++) begin
         av = 4'($urandom); bv = 4'($urandom); cv = 1'($urandom);
         if (i == 0) begin av = 4'hF; bv = 4'h0; cv = 1'b1; end
         exp = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
         in_valid_1 = 1'b1; a_1 = av; b_1 = bv; c_in_1 = cv;
         tick();
         in_valid_1 = 1'b0; a_1 = 4'($urandom); b_1 = 4'($urandom);
         lat = 0;
         while (!out_valid_1 && lat < BOUND) begin tick(); lat++; end
         total_cnt++; if (lat !== 1) $display("FAIL n1_latency[%0d] got=%0d exp=1", i, lat); else pass_cnt++;
         total_cnt++; if ({c_out_1, sum_1} !== exp) $display("FAIL n1_sum[%0d] got=%h exp=%h", i, {c_out_1, sum_1}, exp); else pass_cnt++;
         out_ready_1 = 1'b1;
         tick();
         out_ready_1 = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
      in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; c_in_1 = 1'b0; out_ready_1 = 1'b0;
      test_reset();
      test_directed();
      test_stall();
      test_ignore_in_valid();
      test_reset_abort();
      test_random();
      test_back_to_back();
      test_nibbles1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_nibble_serial_adder
